// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and load/store ports onto the byte-wide system
// bus and serialises 1/2/4-byte accesses into little-endian byte transfers.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          LS_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  flush,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  fetch_q, fetch_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [2:0]            issue_q, issue_d;
  logic [2:0]            cap_q, cap_d;
  logic                  a_valid_q, a_valid_d;
  logic                  din_valid_q, din_valid_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  if_done_q, if_done_d;
  logic                  ls_done_q, ls_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic                  take_ls, take_if, last;
  logic [31:0]           merged;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    fetch_d     = fetch_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    issue_d     = issue_q;
    cap_d       = cap_q;
    a_valid_d   = a_valid_q;
    din_valid_d = din_valid_q;
    mem_a_d     = mem_a_q;
    mem_wr_d    = mem_wr_q;
    mem_dout_d  = mem_dout_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_data_d   = if_data_q;
    ls_rdata_d  = ls_rdata_q;
    take_ls     = 1'b0;
    take_if     = 1'b0;
    last        = 1'b0;
    merged      = buf_q;

    unique case (state_q)
      IDLE: begin
        // requesters update req during a done cycle, so it is not sampled then
        if (rdy && !if_done_q && !ls_done_q) begin
          take_ls = ls_req && (LS_FIRST || !(if_req && !flush));
          take_if = if_req && !flush && !take_ls;
        end
        if (take_ls || take_if) begin
          addr_d      = take_ls ? ls_addr : if_addr;
          size_d      = take_ls ? size_bytes(ls_size) : 3'd4;
          fetch_d     = take_if;
          wdata_d     = ls_wdata;
          buf_d       = '0;
          cap_d       = '0;
          issue_d     = 3'd1;
          a_valid_d   = 1'b1;
          din_valid_d = 1'b0;
          mem_a_d     = take_ls ? ls_addr : if_addr;
          if (take_ls && ls_we) begin
            state_d    = WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = ls_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        if (fetch_q && flush) begin
          state_d     = IDLE;
          a_valid_d   = 1'b0;
          din_valid_d = 1'b0;
        end else if (!rdy) begin
          // rewind to the oldest uncaptured byte; in-flight data is dropped
          mem_a_d     = addr_q + ADDR_WIDTH'(cap_q);
          issue_d     = cap_q + 3'd1;
          a_valid_d   = 1'b1;
          din_valid_d = 1'b0;
        end else begin
          if (din_valid_q) begin
            merged[{cap_q[1:0], 3'b000} +: 8] = mem_din;
            buf_d = merged;
            cap_d = cap_q + 3'd1;
            last  = (cap_q + 3'd1 == size_q);
          end
          if (last) begin
            state_d     = IDLE;
            a_valid_d   = 1'b0;
            din_valid_d = 1'b0;
            if (fetch_q) begin
              if_done_d = 1'b1;
              if_data_d = merged;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = merged;
            end
          end else begin
            din_valid_d = a_valid_q;
            if (issue_q < size_q) begin
              mem_a_d   = addr_q + ADDR_WIDTH'(issue_q);
              issue_d   = issue_q + 3'd1;
              a_valid_d = 1'b1;
            end else begin
              a_valid_d = 1'b0;
            end
          end
        end
      end

      WRITE: begin
        // with rdy low the presented byte is not written; holding re-presents it
        if (rdy) begin
          if (issue_q == size_q) begin
            state_d   = IDLE;
            mem_wr_d  = 1'b0;
            ls_done_d = 1'b1;
          end else begin
            mem_a_d    = addr_q + ADDR_WIDTH'(issue_q);
            mem_dout_d = wdata_q[{issue_q[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            issue_d    = issue_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      fetch_q     <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      issue_q     <= '0;
      cap_q       <= '0;
      a_valid_q   <= 1'b0;
      din_valid_q <= 1'b0;
      mem_a_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_dout_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      fetch_q     <= fetch_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      a_valid_q   <= a_valid_d;
      din_valid_q <= din_valid_d;
      mem_a_q     <= mem_a_d;
      mem_wr_q    <= mem_wr_d;
      mem_dout_q  <= mem_dout_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_data_q   <= if_data_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q & rdy;
  assign mem_dout = mem_dout_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed memory responder plus a reference memory image
// used to predict load/fetch data, bus address sequences and done timing.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_WIDTH(32), .LS_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .flush(flush),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] bg(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : bg(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  // Byte memory: data for the address seen in one cycle appears in the next
  always @(posedge clk) begin
    mem_din <= bus_rd(mem_a);
    if (mem_wr) bus_mem[mem_a] = mem_dout;
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    bus_mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction starting at the current negedge (c0); returns at a negedge after done
  task automatic xact(input bit is_if, input bit we, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n, exp_done, done_at;
    logic [31:0] exp_data, got;
    n = is_if ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
    exp_done = we ? n + 1 : n + 2;
    exp_data = '0;
    got = '0;
    for (int k = 0; k < n; k++)
      exp_data |= 32'(ref_rd(addr + 32'(k))) << (8 * k);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wdata;
    end
    done_at = 0;
    for (int t = 1; t <= 20 && done_at == 0; t++) begin
      if (!is_if) flush = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (t <= n) begin
        chk("mem_a", mem_a, addr + 32'(t - 1));
        chk("mem_wr", 32'(mem_wr), 32'(we));
        if (we) chk("mem_dout", 32'(mem_dout), 32'(8'(wdata >> (8 * (t - 1)))));
      end else begin
        chk("mem_wr_off", 32'(mem_wr), 32'd0);
      end
      if (is_if ? if_done : ls_done) begin
        done_at = t;
        got = is_if ? if_data : ls_rdata;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    flush = 1'b0;
    chk(is_if ? "if_done_cycle" : "ls_done_cycle", 32'(done_at), 32'(exp_done));
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = 8'(wdata >> (8 * k));
    end else begin
      chk(is_if ? "if_data" : "ls_rdata", got, exp_data);
    end
    @(negedge clk);
    chk("done_width", 32'(is_if ? if_done : ls_done), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, prev;
    int ls_at, if_at, done_at;
    logic [31:0] ls_got, if_got;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch of a known instruction word
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    xact(1'b1, 1'b0, 2'b10, 32'h100, '0);
    chk("fetch_word", if_data, 32'h0000_0513);

    // Byte store into the IO region
    xact(1'b0, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
    chk("io_byte", 32'(bus_rd(32'h0003_0000)), 32'h41);

    // Half load wrapping past the top of the address space
    poke(32'hFFFF_FFFF, 8'h34); poke(32'h0000_0000, 8'h12);
    xact(1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, '0);
    chk("wrap_half", ls_rdata, 32'h0000_1234);

    // Simultaneous requests: load/store first, fetch after it
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h400;
    ls_at = 0; if_at = 0; ls_got = '0; if_got = '0;
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      if (ls_done && ls_at == 0) begin ls_at = t; ls_got = ls_rdata; ls_req = 1'b0; end
      if (if_done && if_at == 0) begin if_at = t; if_got = if_data; if_req = 1'b0; end
    end
    ls_req = 1'b0; if_req = 1'b0;
    chk("arb_ls_cycle", 32'(ls_at), 32'd6);
    chk("arb_if_cycle", 32'(if_at), 32'd13);
    d = '0;
    for (int k = 0; k < 4; k++) d |= 32'(ref_rd(32'h200 + 32'(k))) << (8 * k);
    chk("arb_ls_data", ls_got, d);
    d = '0;
    for (int k = 0; k < 4; k++) d |= 32'(ref_rd(32'h400 + 32'(k))) << (8 * k);
    chk("arb_if_data", if_got, d);

    // Flush in c3 of a fetch
    prev = if_data;
    if_req = 1'b1; if_addr = 32'h500;
    for (int t = 1; t <= 3; t++) @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chk("flush_no_done", 32'(if_done), 32'd0);
      chk("flush_mem_wr", 32'(mem_wr), 32'd0);
      @(negedge clk);
    end
    chk("flush_if_data", if_data, prev);
    xact(1'b0, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_007E);

    // Bus stall during c3 of a word load
    poke(32'h300, 8'hDE); poke(32'h301, 8'hAD); poke(32'h302, 8'hBE); poke(32'h303, 8'hEF);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h300;
    done_at = 0; ls_got = '0;
    for (int t = 1; t <= 20 && done_at == 0; t++) begin
      @(negedge clk);
      if (t == 3) rdy = 1'b0;
      if (t == 4) begin
        rdy = 1'b1;
        chk("stall_represent", mem_a, 32'h301);
      end
      chk("stall_mem_wr", 32'(mem_wr), 32'd0);
      if (ls_done) begin done_at = t; ls_got = ls_rdata; end
    end
    ls_req = 1'b0; rdy = 1'b1;
    chk("stall_done_seen", 32'(done_at > 0), 32'd1);
    chk("stall_data", ls_got, 32'hEFBE_ADDE);
    @(negedge clk);

    // Reset in the middle of a word store
    d = 32'hC3B2_A190;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h600; ls_wdata = d;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_mem_a", mem_a, 32'd0);
    chk("mrst_mem_wr", 32'(mem_wr), 32'd0);
    chk("mrst_mem_dout", 32'(mem_dout), 32'd0);
    chk("mrst_ls_done", 32'(ls_done), 32'd0);
    chk("mrst_if_data", if_data, 32'd0);
    chk("mrst_ls_rdata", ls_rdata, 32'd0);
    ls_req = 1'b0;
    ref_mem[32'h600] = d[7:0];
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("mrst_no_done", 32'(ls_done), 32'd0);
    end
    xact(1'b0, 1'b0, 2'b10, 32'h600, '0);

    // Randomised traffic against the reference image
    for (int i = 0; i < 40; i++) begin
      bit is_if, we;
      logic [1:0] sz;
      int sel;
      is_if = ($urandom_range(0, 3) == 0);
      we = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 2);
      case (sel)
        0:       a = $urandom;
        1:       a = 32'h0003_0000 | 32'($urandom_range(0, 16'hFFFF));
        default: a = 32'hFFFF_FFFD + 32'($urandom_range(0, 4));
      endcase
      d = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xact(is_if, we, sz, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
